spi_slave: RTL

SPI_SLAVE -- requirements
Module: spi_slave

---
 rtl/spi_pkg.sv | 16 +
 rtl/sync_edge.sv | 31 +++
 rtl/spi_slave.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared state encoding and tx fill byte for the SPI slave
package spi_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } spi_state_t;

  localparam logic [7:0] IDLE_FILL = 8'h00;

  // Byte the tx shifter takes at frame start and at each byte boundary.
  function automatic logic [7:0] next_tx_byte(input logic empty, input logic [7:0] buffer);
    return empty ? IDLE_FILL : buffer;
  endfunction

endpackage

// File: rtl/sync_edge.sv
// rtl/sync_edge.sv - multi-flop synchronizer with registered level and rise/fall pulses
module sync_edge #(
  parameter int   STAGES     = 2,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic raw_clk,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;

  // level is delayed one flop past the chain so it lines up with rise/fall.
  always_ff @(posedge raw_clk) begin
    if (reset) begin
      chain <= {STAGES{IDLE_LEVEL}};
      level <= IDLE_LEVEL;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      chain <= {chain[STAGES-2:0], din};
      level <= chain[STAGES-1];
      rise  <= chain[STAGES-1] & ~level;
      fall  <= ~chain[STAGES-1] & level;
    end
  end

endmodule

// File: rtl/spi_slave.sv
// rtl/spi_slave.sv - SPI mode 0 slave, 8-bit MSB-first frames, oversampled on raw_clk
module spi_slave
  import spi_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       raw_clk,
  input  logic       reset,
  input  logic       sclk,
  input  logic       cs_n,
  input  logic       mosi,
  output logic       miso,
  output logic       miso_oe,
  input  logic [7:0] tx_data,
  input  logic       tx_load,
  output logic       tx_empty,
  output logic [7:0] rx_data,
  output logic       rx_ready,
  input  logic       rx_ready_clear,
  output logic       rx_overrun,
  output logic       busy
);

  localparam int SETTLE = SYNC_STAGES + 2;
  localparam int SW     = $clog2(SETTLE + 1);

  logic sclk_lvl, sclk_rise, sclk_fall;
  logic cs_lvl, cs_rise, cs_fall;
  logic mosi_lvl, mosi_rise, mosi_fall;
  logic unused_sync;

  sync_edge #(.STAGES(SYNC_STAGES), .IDLE_LEVEL(1'b0)) u_sync_sclk (
    .raw_clk(raw_clk), .reset(reset), .din(sclk),
    .level(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES), .IDLE_LEVEL(1'b1)) u_sync_cs (
    .raw_clk(raw_clk), .reset(reset), .din(cs_n),
    .level(cs_lvl), .rise(cs_rise), .fall(cs_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES), .IDLE_LEVEL(1'b0)) u_sync_mosi (
    .raw_clk(raw_clk), .reset(reset), .din(mosi),
    .level(mosi_lvl), .rise(mosi_rise), .fall(mosi_fall)
  );

  assign unused_sync = &{1'b0, sclk_lvl, cs_rise, mosi_rise, mosi_fall};

  spi_state_t      state;
  logic [2:0]      bit_cnt;
  logic [6:0]      rx_shift;
  logic [7:0]      tx_shift;
  logic [7:0]      tx_buf;
  logic [7:0]      next_tx;
  logic            byte_done;
  logic [SW-1:0]   settle_cnt;
  logic            armed;

  assign next_tx = next_tx_byte(tx_empty, tx_buf);
  assign miso    = miso_oe & tx_shift[7];

  // armed only once cs_n is seen high after the synchronizers have flushed
  // their reset value, so a select held low across reset cannot start a frame.
  always_ff @(posedge raw_clk) begin
    if (reset) begin
      state      <= IDLE;
      bit_cnt    <= 3'd0;
      rx_shift   <= 7'd0;
      tx_shift   <= 8'd0;
      tx_buf     <= 8'd0;
      tx_empty   <= 1'b1;
      rx_data    <= 8'd0;
      rx_ready   <= 1'b0;
      rx_overrun <= 1'b0;
      miso_oe    <= 1'b0;
      busy       <= 1'b0;
      byte_done  <= 1'b0;
      settle_cnt <= '0;
      armed      <= 1'b0;
    end else begin
      if (settle_cnt != SW'(SETTLE)) begin
        settle_cnt <= settle_cnt + SW'(1);
      end else if (cs_lvl) begin
        armed <= 1'b1;
      end

      if (rx_ready_clear) begin
        rx_ready   <= 1'b0;
        rx_overrun <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (cs_fall && armed) begin
            state     <= SHIFT;
            tx_shift  <= next_tx;
            tx_empty  <= 1'b1;
            bit_cnt   <= 3'd0;
            byte_done <= 1'b0;
            miso_oe   <= 1'b1;
            busy      <= 1'b1;
          end
        end
        SHIFT: begin
          if (cs_lvl) begin
            state     <= IDLE;
            miso_oe   <= 1'b0;
            busy      <= 1'b0;
            bit_cnt   <= 3'd0;
            byte_done <= 1'b0;
          end else if (sclk_rise) begin
            rx_shift <= {rx_shift[5:0], mosi_lvl};
            bit_cnt  <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              rx_data   <= {rx_shift, mosi_lvl};
              rx_ready  <= 1'b1;
              byte_done <= 1'b1;
              if (rx_ready && !rx_ready_clear) begin
                rx_overrun <= 1'b1;
              end
            end
          end else if (sclk_fall) begin
            if (byte_done) begin
              tx_shift  <= next_tx;
              tx_empty  <= 1'b1;
              byte_done <= 1'b0;
            end else begin
              tx_shift <= {tx_shift[6:0], 1'b0};
            end
          end
        end
        default: state <= IDLE;
      endcase

      // A load in the same cycle as a reload lands after it: the reload took
      // the old buffer and the new byte stays pending.
      if (tx_load) begin
        tx_buf   <= tx_data;
        tx_empty <= 1'b0;
      end
    end
  end

endmodule
